pixel_compositor: RTL

//  Downstream stage of the sprite/ROM path: consumes per-layer colour indices returned by sprite ROMs,
//  re-aligns them with display timing (bright, hCount, vCount), resolves priority/transparency,

---
 rtl/disp_pkg.sv | 24 ++
 rtl/delay_line.sv | 34 +++
 rtl/pixel_compositor.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared display constants: visible geometry, RGB332 palette, transparent index
// and the collision-tracker state type.
package disp_pkg;

  localparam int H_VIS = 640;
  localparam int V_VIS = 480;
  localparam int CORDW = 10;
  localparam int TRANSP_IDX = 0;

  localparam logic [7:0] PALETTE [0:7] = '{
    8'h00, 8'hE0, 8'h1C, 8'h03,
    8'hFC, 8'hE3, 8'h1F, 8'hFF
  };

  typedef enum logic {
    IDLE,
    ACCUM
  } coll_state_e;

  function automatic logic [7:0] pal(input logic [2:0] idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/delay_line.sv
// Synchronous-reset shift register, DEPTH stages of W bits.
// Realigns address-cycle timing signals with ROM read data.
module delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage_q [DEPTH];
  logic [W-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++)
      stage_d[i] = stage_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        stage_q[i] <= stage_d[i];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/pixel_compositor.sv
// Sprite-layer compositor: priority/transparency resolve, palette, registered RGB.
// Define COMPOSITOR_COLLISION_EN to enable the per-frame layer-overlap flag.
module pixel_compositor
  import disp_pkg::*;
#(
  parameter int         NLAYERS  = 3,
  parameter int         CIDXW    = 3,
  parameter int         ROM_LAT  = 1,
  parameter int         RGBW     = 8,
  parameter logic [7:0] BG_COLOR = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bright,
  input  logic [9:0]               hCount,
  input  logic [9:0]               vCount,
  input  logic [NLAYERS-1:0]       layer_en,
  input  logic [NLAYERS*CIDXW-1:0] layer_idx,
  output logic [RGBW-1:0]          rgb,
  output logic [9:0]               pix_x,
  output logic [9:0]               pix_y,
  output logic                     pix_vld,
  output logic                     collision
);

  localparam int AW = 21 + NLAYERS;

  logic [AW-1:0]      aligned;
  logic               bright_d;
  logic [9:0]         hcnt_d;
  logic [9:0]         vcnt_d;
  logic [NLAYERS-1:0] en_d;

  delay_line #(
    .W     (AW),
    .DEPTH (ROM_LAT)
  ) u_align (
    .clk  (clk),
    .rst  (rst),
    .din  ({bright, hCount, vCount, layer_en}),
    .dout (aligned)
  );

  assign {bright_d, hcnt_d, vcnt_d, en_d} = aligned;

  logic             found;
  logic             multi;
  logic [CIDXW-1:0] win_idx;
  logic [CIDXW-1:0] cur_idx;

  // Ascending scan: first opaque layer wins, any later one marks an overlap.
  always_comb begin
    found   = 1'b0;
    multi   = 1'b0;
    win_idx = '0;
    cur_idx = '0;
    for (int k = 0; k < NLAYERS; k++) begin
      cur_idx = layer_idx[k*CIDXW +: CIDXW];
      if (en_d[k] && cur_idx != CIDXW'(TRANSP_IDX)) begin
        if (found) begin
          multi = 1'b1;
        end else begin
          found   = 1'b1;
          win_idx = cur_idx;
        end
      end
    end
  end

  logic [RGBW-1:0] rgb_q, rgb_d;
  logic [9:0]      pix_x_q, pix_y_q;
  logic            pix_vld_q;

  always_comb begin
    rgb_d = '0;
    if (bright_d)
      rgb_d = found ? RGBW'(pal(3'(win_idx))) : RGBW'(BG_COLOR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q     <= '0;
      pix_x_q   <= '0;
      pix_y_q   <= '0;
      pix_vld_q <= 1'b0;
    end else begin
      rgb_q     <= rgb_d;
      pix_x_q   <= hcnt_d;
      pix_y_q   <= vcnt_d;
      pix_vld_q <= bright_d;
    end
  end

  assign rgb     = rgb_q;
  assign pix_x   = pix_x_q;
  assign pix_y   = pix_y_q;
  assign pix_vld = pix_vld_q;

`ifdef COMPOSITOR_COLLISION_EN
  coll_state_e state_q, state_d;
  logic        hit_acc_q, hit_acc_d;
  logic        collision_q, collision_d;
  logic        sof;
  logic        hit;

  // Frame start is judged on the aligned stage so (0,0) updates with its own pixel.
  assign sof = bright_d && hcnt_d == '0 && vcnt_d == '0;
  assign hit = multi && bright_d;

  always_comb begin
    state_d     = state_q;
    hit_acc_d   = hit_acc_q;
    collision_d = collision_q;
    unique case (state_q)
      IDLE: begin
        if (sof) begin
          state_d   = ACCUM;
          hit_acc_d = hit;
        end
      end
      ACCUM: begin
        if (sof) begin
          collision_d = hit_acc_q;
          hit_acc_d   = hit;
        end else begin
          hit_acc_d = hit_acc_q | hit;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hit_acc_q   <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hit_acc_q   <= hit_acc_d;
      collision_q <= collision_d;
    end
  end

  assign collision = collision_q;
`else
  logic unused_multi;
  assign unused_multi = multi;
  assign collision    = 1'b0;
`endif

endmodule
